nn_out_argmax: RTL and testbench

- Downstream consumer of the NN recurrent core.
- Takes NN's serial fp32 output stream (`out_valid`/`out`) and groups it into vectors of VEC_LEN elements.
- For each vector, finds the index of the largest element and its value.
- Queues the results in a small FIFO and presents them on a valid/ready interface to the next consumer (scoreboard or host readout).

---
 rtl/nn_pkg.sv | 31 +++
 rtl/nn_res_fifo.sv | 74 +++++++
 rtl/nn_out_argmax.sv | 101 ++++++++++
 tb/tb_nn_out_argmax.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared types and constants for the NN output argmax block: fp32 layout,
// vector geometry, the result record and the fp32 total-order key.
package nn_pkg;

    localparam int SIG_W      = 23;
    localparam int EXP_W      = 8;
    localparam int DATA_W     = 1 + EXP_W + SIG_W;
    localparam int VEC_LEN    = 3;
    localparam int IDX_W      = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int VID_W      = 4;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] max;
        logic [VID_W-1:0]  vid;
    } nn_res_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } nn_state_e;

    // Maps an fp32 bit pattern onto an unsigned key whose ordering matches
    // numeric ordering (with -0 below +0); NaN/Inf are just bit patterns here.
    function automatic logic [DATA_W-1:0] fp_order_key(input logic [DATA_W-1:0] x);
        return x[DATA_W-1] ? ~x : (x ^ {1'b1, {(DATA_W-1){1'b0}}});
    endfunction

endpackage

// File: rtl/nn_res_fifo.sv
// Result FIFO with a registered head: out_valid/head update on the clock edge,
// and the head holds its last value while the FIFO is empty.
module nn_res_fifo
    import nn_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  nn_res_t push_data,
    input  logic    out_ready,
    output logic    out_valid,
    output nn_res_t head,
    output logic    drop
);

    // Handshake: the head entry is consumed on any rising edge where
    // out_valid && out_ready; a push into a full FIFO is only accepted when
    // that same edge also pops.
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

    nn_res_t          mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_nxt;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_d;
    logic             pop;
    logic             full;
    logic             push_ok;

    assign pop     = out_valid && out_ready;
    assign full    = (count == FULL_CNT);
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;
    assign rd_nxt  = rd_ptr + 1'b1;
    assign count_d = count + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            head      <= '0;
        end else begin
            count     <= count_d;
            out_valid <= (count_d != '0);
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_nxt;
            end
            // Next head comes from storage if another entry is queued behind
            // the popped one, otherwise straight from the incoming push.
            if (pop) begin
                if (count > (PTR_W+1)'(1)) begin
                    head <= mem[rd_nxt];
                end else if (push_ok) begin
                    head <= push_data;
                end
            end else if (count == '0 && push_ok) begin
                head <= push_data;
            end
        end
    end

endmodule

// File: rtl/nn_out_argmax.sv
// Groups the NN serial fp32 output stream into VEC_LEN-element vectors and
// queues {argmax index, max value, vector id} for a valid/ready consumer.
module nn_out_argmax
    import nn_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_idx,
    output logic [DATA_W-1:0] out_max,
    output logic [VID_W-1:0]  out_vid,
    output logic              overflow
);

    localparam logic [IDX_W:0] LAST_CNT = (IDX_W+1)'(VEC_LEN);

    nn_state_e         state_q, state_d;
    logic [IDX_W:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [VID_W-1:0]  vid_q;
    logic              overflow_q;
    logic              push;
    nn_res_t           push_res;
    logic              drop;
    nn_res_t           head;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        max_d    = max_q;
        idx_d    = idx_q;
        push     = 1'b0;
        push_res = '0;
        if (in_valid) begin
            if (state_q == ST_IDLE) begin
                max_d = in_data;
                idx_d = '0;
                cnt_d = (IDX_W+1)'(1);
            end else begin
                // Strict greater-than keeps the lower index on ties.
                if (fp_order_key(in_data) > fp_order_key(max_q)) begin
                    max_d = in_data;
                    idx_d = cnt_q[IDX_W-1:0];
                end
                cnt_d = cnt_q + 1'b1;
            end
            if (cnt_d == LAST_CNT) begin
                push     = 1'b1;
                push_res = '{idx: idx_d, max: max_d, vid: vid_q};
                state_d  = ST_IDLE;
                cnt_d    = '0;
            end else begin
                state_d  = ST_ACC;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            max_q      <= '0;
            idx_q      <= '0;
            vid_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            max_q   <= max_d;
            idx_q   <= idx_d;
            // The id advances even when the FIFO drops the result.
            if (push) begin
                vid_q <= vid_q + 1'b1;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    nn_res_fifo u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_res),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .head      (head),
        .drop      (drop)
    );

    assign out_idx  = head.idx;
    assign out_max  = head.max;
    assign out_vid  = head.vid;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_nn_out_argmax.sv
// Bench for nn_out_argmax: directed vectors plus random traffic, checked
// against a sign/magnitude argmax model and an expected-result queue.
module tb_nn_out_argmax;
    import nn_pkg::*;

    localparam int RES_W = IDX_W + DATA_W + VID_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [IDX_W-1:0]  out_idx;
    logic [DATA_W-1:0] out_max;
    logic [VID_W-1:0]  out_vid;
    logic              overflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: current partial vector, expected FIFO contents, head shown.
    logic [DATA_W-1:0] cur_vec [$];
    logic [RES_W-1:0]  exp_q [$];
    logic [RES_W-1:0]  last_head = '0;
    logic [VID_W-1:0]  vid_m = '0;
    logic              ovf_m = 1'b0;

    always #5 clk = ~clk;

    nn_out_argmax dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_max   (out_max),
        .out_vid   (out_vid),
        .overflow  (overflow)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // a < b in numeric order, with -0 below +0.
    function automatic bit fp_less(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        if (a[DATA_W-1] != b[DATA_W-1]) return a[DATA_W-1];
        if (!a[DATA_W-1]) return a[DATA_W-2:0] < b[DATA_W-2:0];
        return a[DATA_W-2:0] > b[DATA_W-2:0];
    endfunction

    task automatic model_reset();
        cur_vec.delete();
        exp_q.delete();
        last_head = '0;
        vid_m     = '0;
        ovf_m     = 1'b0;
    endtask

    task automatic check_outputs();
        check_eq("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
        check_eq("out_idx", 64'(out_idx), 64'(last_head[RES_W-1 -: IDX_W]));
        check_eq("out_max", 64'(out_max), 64'(last_head[VID_W +: DATA_W]));
        check_eq("out_vid", 64'(out_vid), 64'(last_head[VID_W-1:0]));
        check_eq("overflow", 64'(overflow), 64'(ovf_m));
    endtask

    // One clock cycle: check state left by the previous edge, then drive the
    // inputs for the next edge and advance the model accordingly.
    task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic rdy);
        int best;
        @(negedge clk);
        check_outputs();
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
        if (v) begin
            cur_vec.push_back(d);
            if (cur_vec.size() == VEC_LEN) begin
                best = 0;
                for (int i = 1; i < VEC_LEN; i++)
                    if (fp_less(cur_vec[best], cur_vec[i])) best = i;
                if (exp_q.size() < FIFO_DEPTH)
                    exp_q.push_back({IDX_W'(best), cur_vec[best], vid_m});
                else
                    ovf_m = 1'b1;
                vid_m = vid_m + 1'b1;
                cur_vec.delete();
            end
        end
        if (exp_q.size() != 0) last_head = exp_q[0];
    endtask

    task automatic send_vec(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                            input logic [DATA_W-1:0] c, input logic rdy);
        step(1'b1, a, rdy);
        step(1'b1, b, rdy);
        step(1'b1, c, rdy);
    endtask

    // Directed look at the head just after the edge that follows the last element.
    task automatic peek_head(input logic [IDX_W-1:0] ei, input logic [DATA_W-1:0] em,
                             input logic [VID_W-1:0] ev);
        @(posedge clk);
        #1;
        check_eq("peek_valid", 64'(out_valid), 64'(1));
        check_eq("peek_idx", 64'(out_idx), 64'(ei));
        check_eq("peek_max", 64'(out_max), 64'(em));
        check_eq("peek_vid", 64'(out_vid), 64'(ev));
    endtask

    task automatic pulse_reset();
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_eq("rst_valid", 64'(out_valid), 64'(0));
        check_eq("rst_idx", 64'(out_idx), 64'(0));
        check_eq("rst_max", 64'(out_max), 64'(0));
        check_eq("rst_vid", 64'(out_vid), 64'(0));
        check_eq("rst_overflow", 64'(overflow), 64'(0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [DATA_W-1:0] rand_word(input logic [DATA_W-1:0] prev);
        case ($urandom_range(0, 9))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'h3F80_0000;
            3: return 32'hBF80_0000;
            4: return 32'h7F80_0000;
            5: return prev;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [DATA_W-1:0] w;
        w = '0;
        #1;
        check_eq("por_valid", 64'(out_valid), 64'(0));
        check_eq("por_overflow", 64'(overflow), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Positive maximum
        send_vec(32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 1'b1);
        peek_head(2'd1, 32'h4000_0000, 4'd0);
        step(1'b0, 32'hDEAD_BEEF, 1'b1);

        // All negative
        send_vec(32'hC040_0000, 32'hBF80_0000, 32'hC000_0000, 1'b1);
        peek_head(2'd1, 32'hBF80_0000, 4'd1);
        step(1'b0, '0, 1'b1);

        // Tie with gaps in in_valid
        step(1'b1, 32'h4000_0000, 1'b1);
        repeat (3) step(1'b0, 32'h7F00_0000, 1'b1);
        step(1'b1, 32'h4000_0000, 1'b1);
        step(1'b1, 32'h3F80_0000, 1'b1);
        peek_head(2'd0, 32'h4000_0000, 4'd2);
        repeat (2) step(1'b0, '0, 1'b1);

        // Signed zero
        send_vec(32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 1'b1);
        peek_head(2'd1, 32'h0000_0000, 4'd3);
        step(1'b0, '0, 1'b1);

        // Overflow: five vectors into a stalled consumer, then drain
        pulse_reset();
        send_vec(32'h4000_0000, 32'h3F80_0000, 32'h3F00_0000, 1'b0);
        send_vec(32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 1'b0);
        send_vec(32'h3F00_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0);
        send_vec(32'h4040_0000, 32'h3F80_0000, 32'h3F00_0000, 1'b0);
        send_vec(32'h3F80_0000, 32'h4040_0000, 32'h3F00_0000, 1'b0);
        @(posedge clk);
        #1;
        check_eq("ovf_sticky", 64'(overflow), 64'(1));
        check_eq("ovf_head_vid", 64'(out_vid), 64'(0));
        repeat (6) step(1'b0, '0, 1'b1);

        // Reset in the middle of a vector
        step(1'b1, 32'h4100_0000, 1'b1);
        step(1'b1, 32'h4200_0000, 1'b1);
        pulse_reset();
        send_vec(32'h3F00_0000, 32'h3F80_0000, 32'h4000_0000, 1'b1);
        peek_head(2'd2, 32'h4000_0000, 4'd0);
        check_eq("post_rst_overflow", 64'(overflow), 64'(0));
        step(1'b0, '0, 1'b1);

        // Random traffic with back-pressure and occasional overflow
        for (int i = 0; i < 400; i++) begin
            w = rand_word(w);
            step(($urandom_range(0, 9) < 7), w, ($urandom_range(0, 3) != 0) || (i > 360));
        end
        repeat (8) step(1'b0, '0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
